// File: rtl/id_ex_register_if.sv
// Bundles the decode-side inputs, forwarding inputs and execute-side outputs of the ID/EX pipeline register.
interface id_ex_register_if;
  logic        StallE, FlushE, ValidD;
  logic [31:0] PCD, RD1D, RD2D, ImmExtD;
  logic [4:0]  Rs1D, Rs2D, RdD;
  logic [6:0]  OpD;
  logic [2:0]  Funct3D;
  logic        Funct7b5D;
  logic [1:0]  ALUSrcAD;
  logic        ALUSrcBD, RegWriteD, MemWriteD;
  logic [1:0]  ResultSrcD;
  logic        BranchD, JumpD;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] ALUResultM, ResultW;

  logic [31:0] SrcAE, SrcBE, WriteDataE, PCE, ImmExtE;
  logic [3:0]  ALUControlE;
  logic [4:0]  Rs1E, Rs2E, RdE;
  logic        RegWriteE, MemWriteE, BranchE, JumpE;
  logic [1:0]  ResultSrcE;
  logic        ValidE, IllegalE;

  modport master (
    output StallE, FlushE, ValidD, PCD, RD1D, RD2D, ImmExtD, Rs1D, Rs2D, RdD,
           OpD, Funct3D, Funct7b5D, ALUSrcAD, ALUSrcBD, RegWriteD, MemWriteD,
           ResultSrcD, BranchD, JumpD, ForwardAE, ForwardBE, ALUResultM, ResultW,
    input  SrcAE, SrcBE, WriteDataE, PCE, ImmExtE, ALUControlE, Rs1E, Rs2E, RdE,
           RegWriteE, MemWriteE, BranchE, JumpE, ResultSrcE, ValidE, IllegalE
  );

  modport slave (
    input  StallE, FlushE, ValidD, PCD, RD1D, RD2D, ImmExtD, Rs1D, Rs2D, RdD,
           OpD, Funct3D, Funct7b5D, ALUSrcAD, ALUSrcBD, RegWriteD, MemWriteD,
           ResultSrcD, BranchD, JumpD, ForwardAE, ForwardBE, ALUResultM, ResultW,
    output SrcAE, SrcBE, WriteDataE, PCE, ImmExtE, ALUControlE, Rs1E, Rs2E, RdE,
           RegWriteE, MemWriteE, BranchE, JumpE, ResultSrcE, ValidE, IllegalE
  );
endinterface

// File: rtl/id_ex_register.sv
// ID/EX pipeline register: one-cycle D->E with registered ALU decode; StallE holds, FlushE (wins) inserts a bubble.
// Execute-side operand forwarding is combinational and only active when FORWARDING_EN is defined.
module id_ex_register (
  input  logic            clk,
  input  logic            reset,
  id_ex_register_if.slave bus
);
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  logic [3:0]  alu_ctrl_d;
  logic        illegal_d;

  logic        valid_e, regwrite_e, memwrite_e, branch_e, jump_e, illegal_e;
  logic [3:0]  alu_ctrl_e;
  logic [1:0]  alusrca_e, resultsrc_e;
  logic        alusrcb_e;
  logic [31:0] pc_e, rd1_e, rd2_e, imm_e;
  logic [4:0]  rs1_e, rs2_e, rd_e;
  logic [31:0] fwd_a, fwd_b, srca;

  always_comb begin
    alu_ctrl_d = 4'b0000;
    illegal_d  = 1'b0;
    case (bus.OpD)
      OP_R: begin
        if (bus.Funct7b5D && bus.Funct3D != 3'b000 && bus.Funct3D != 3'b101)
          illegal_d = 1'b1;
        else
          alu_ctrl_d = {bus.Funct7b5D, bus.Funct3D};
      end
      // Only shift-right immediates use instr[30]; elsewhere it is immediate data.
      OP_I: alu_ctrl_d = (bus.Funct3D == 3'b101) ? {bus.Funct7b5D, 3'b101} : {1'b0, bus.Funct3D};
      OP_B: begin
        case (bus.Funct3D)
          3'b000, 3'b001: alu_ctrl_d = 4'b1000;
          3'b100, 3'b101: alu_ctrl_d = 4'b0010;
          3'b110, 3'b111: alu_ctrl_d = 4'b0011;
          default:        illegal_d  = 1'b1;
        endcase
      end
      OP_LOAD, OP_STORE, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: alu_ctrl_d = 4'b0000;
      default: illegal_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_e    <= 1'b0;
      regwrite_e <= 1'b0;
      memwrite_e <= 1'b0;
      branch_e   <= 1'b0;
      jump_e     <= 1'b0;
      illegal_e  <= 1'b0;
      alu_ctrl_e <= 4'b0000;
    end else if (bus.FlushE || (!bus.StallE && !bus.ValidD)) begin
      valid_e    <= 1'b0;
      regwrite_e <= 1'b0;
      memwrite_e <= 1'b0;
      branch_e   <= 1'b0;
      jump_e     <= 1'b0;
      illegal_e  <= 1'b0;
      alu_ctrl_e <= 4'b0000;
    end else if (!bus.StallE) begin
      valid_e    <= 1'b1;
      regwrite_e <= bus.RegWriteD;
      memwrite_e <= bus.MemWriteD;
      branch_e   <= bus.BranchD;
      jump_e     <= bus.JumpD;
      illegal_e  <= illegal_d;
      alu_ctrl_e <= alu_ctrl_d;
    end
  end

  // Data fields are don't-care inside a bubble, so a flush simply loads them too.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alusrca_e   <= 2'b00;
      alusrcb_e   <= 1'b0;
      resultsrc_e <= 2'b00;
      pc_e        <= '0;
      rd1_e       <= '0;
      rd2_e       <= '0;
      imm_e       <= '0;
      rs1_e       <= '0;
      rs2_e       <= '0;
      rd_e        <= '0;
    end else if (bus.FlushE || !bus.StallE) begin
      alusrca_e   <= bus.ALUSrcAD;
      alusrcb_e   <= bus.ALUSrcBD;
      resultsrc_e <= bus.ResultSrcD;
      pc_e        <= bus.PCD;
      rd1_e       <= bus.RD1D;
      rd2_e       <= bus.RD2D;
      imm_e       <= bus.ImmExtD;
      rs1_e       <= bus.Rs1D;
      rs2_e       <= bus.Rs2D;
      rd_e        <= bus.RdD;
    end
  end

`ifdef FORWARDING_EN
  always_comb begin
    case (bus.ForwardAE)
      2'b10:   fwd_a = bus.ALUResultM;
      2'b01:   fwd_a = bus.ResultW;
      default: fwd_a = rd1_e;
    endcase
    case (bus.ForwardBE)
      2'b10:   fwd_b = bus.ALUResultM;
      2'b01:   fwd_b = bus.ResultW;
      default: fwd_b = rd2_e;
    endcase
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{bus.ForwardAE, bus.ForwardBE, bus.ALUResultM, bus.ResultW};
  assign fwd_a = rd1_e;
  assign fwd_b = rd2_e;
`endif

  always_comb begin
    case (alusrca_e)
      2'b00:   srca = fwd_a;
      2'b01:   srca = pc_e;
      default: srca = 32'h0;
    endcase
  end

  assign bus.SrcAE       = srca;
  assign bus.SrcBE       = alusrcb_e ? imm_e : fwd_b;
  assign bus.WriteDataE  = fwd_b;
  assign bus.PCE         = pc_e;
  assign bus.ImmExtE     = imm_e;
  assign bus.Rs1E        = rs1_e;
  assign bus.Rs2E        = rs2_e;
  assign bus.RdE         = rd_e;
  assign bus.ALUControlE = alu_ctrl_e;
  assign bus.RegWriteE   = regwrite_e;
  assign bus.MemWriteE   = memwrite_e;
  assign bus.BranchE     = branch_e;
  assign bus.JumpE       = jump_e;
  assign bus.ResultSrcE  = resultsrc_e;
  assign bus.ValidE      = valid_e;
  assign bus.IllegalE    = illegal_e;
endmodule

// File: tb/tb_id_ex_register.sv
// Bench for id_ex_register: instruction-level reference model checked every cycle, plus literal spot checks.
module tb_id_ex_register;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  id_ex_register_if bus();
  id_ex_register dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;
  logic started = 1'b0;
  logic [31:0] pc_cnt = 32'h1000;
  logic [31:0] last_pc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference decode: returns {illegal, alu_control}
  function automatic logic [4:0] ref_decode(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    if (op == 7'b0110011) begin
      if (f7 && !(f3 == 3'd0 || f3 == 3'd5)) return 5'b1_0000;
      return {1'b0, f7, f3};
    end
    if (op == 7'b0010011) return {1'b0, (f3 == 3'd5) ? f7 : 1'b0, f3};
    if (op == 7'b1100011) begin
      case (f3 / 2)
        0:       return 5'b0_1000;
        2:       return 5'b0_0010;
        3:       return 5'b0_0011;
        default: return 5'b1_0000;
      endcase
    end
    if (op inside {7'b0000011, 7'b0100011, 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111})
      return 5'b0_0000;
    return 5'b1_0000;
  endfunction

  function automatic logic [31:0] ref_fwd(input logic [1:0] sel, input logic [31:0] base,
                                          input logic [31:0] alum, input logic [31:0] resw);
`ifdef FORWARDING_EN
    if (sel == 2'b10) return alum;
    if (sel == 2'b01) return resw;
`endif
    return base;
  endfunction

  typedef struct {
    logic valid, regw, memw, br, jmp, ill;
    logic [3:0] ctrl;
    logic known;
    logic [1:0] sa, rsrc;
    logic sb;
    logic [31:0] pc, rd1, rd2, imm;
    logic [4:0] rs1, rs2, rd;
  } mdl_t;
  mdl_t m;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m <= '{default: '0, known: 1'b1};
    end else if (bus.FlushE || (!bus.StallE && !bus.ValidD)) begin
      m <= '{default: '0, known: 1'b0};
    end else if (!bus.StallE) begin
      m <= '{valid: 1'b1, regw: bus.RegWriteD, memw: bus.MemWriteD, br: bus.BranchD,
             jmp: bus.JumpD, ill: ref_decode(bus.OpD, bus.Funct3D, bus.Funct7b5D) >> 4,
             ctrl: ref_decode(bus.OpD, bus.Funct3D, bus.Funct7b5D) & 5'h0f, known: 1'b1,
             sa: bus.ALUSrcAD, rsrc: bus.ResultSrcD, sb: bus.ALUSrcBD, pc: bus.PCD,
             rd1: bus.RD1D, rd2: bus.RD2D, imm: bus.ImmExtD, rs1: bus.Rs1D,
             rs2: bus.Rs2D, rd: bus.RdD};
    end
  end

  logic [31:0] exp_fa, exp_fb, exp_sa;
  always @(negedge clk) begin
    if (started) begin
      check("ValidE", bus.ValidE, m.valid);
      check("RegWriteE", bus.RegWriteE, m.regw);
      check("MemWriteE", bus.MemWriteE, m.memw);
      check("BranchE/JumpE", {bus.BranchE, bus.JumpE}, {m.br, m.jmp});
      check("IllegalE", bus.IllegalE, m.ill);
      check("ALUControlE", bus.ALUControlE, m.ctrl);
      if (m.known) begin
        exp_fa = ref_fwd(bus.ForwardAE, m.rd1, bus.ALUResultM, bus.ResultW);
        exp_fb = ref_fwd(bus.ForwardBE, m.rd2, bus.ALUResultM, bus.ResultW);
        exp_sa = (m.sa == 2'd0) ? exp_fa : (m.sa == 2'd1) ? m.pc : 32'h0;
        check("SrcAE", bus.SrcAE, exp_sa);
        check("SrcBE", bus.SrcBE, m.sb ? m.imm : exp_fb);
        check("WriteDataE", bus.WriteDataE, exp_fb);
        check("PCE", bus.PCE, m.pc);
        check("ImmExtE", bus.ImmExtE, m.imm);
        check("regidx", {bus.Rs1E, bus.Rs2E, bus.RdE}, {m.rs1, m.rs2, m.rd});
        check("ResultSrcE", bus.ResultSrcE, m.rsrc);
      end
    end
  end

  // ctl = {valid, regwrite, memwrite, branch, jump}
  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                       input logic [1:0] sa, input logic sb, input logic [4:0] ctl,
                       input logic stall, input logic flush);
    @(negedge clk); #1;
    bus.StallE = stall;  bus.FlushE = flush;
    bus.OpD = op;  bus.Funct3D = f3;  bus.Funct7b5D = f7;
    bus.RD1D = a;  bus.RD2D = b;  bus.ImmExtD = imm;
    bus.ALUSrcAD = sa;  bus.ALUSrcBD = sb;
    {bus.ValidD, bus.RegWriteD, bus.MemWriteD, bus.BranchD, bus.JumpD} = ctl;
    bus.PCD = pc_cnt;  bus.Rs1D = pc_cnt[6:2];  bus.Rs2D = pc_cnt[7:3];  bus.RdD = pc_cnt[8:4];
    bus.ResultSrcD = f3[1:0];
    if (!stall) last_pc = pc_cnt;
    pc_cnt = pc_cnt + 32'd4;
    @(posedge clk); #1;
  endtask

  initial begin
    bus.StallE = 0; bus.FlushE = 0; bus.ValidD = 0;
    bus.PCD = 0; bus.RD1D = 0; bus.RD2D = 0; bus.ImmExtD = 0;
    bus.Rs1D = 0; bus.Rs2D = 0; bus.RdD = 0; bus.OpD = 0; bus.Funct3D = 0; bus.Funct7b5D = 0;
    bus.ALUSrcAD = 0; bus.ALUSrcBD = 0; bus.RegWriteD = 0; bus.MemWriteD = 0;
    bus.ResultSrcD = 0; bus.BranchD = 0; bus.JumpD = 0;
    bus.ForwardAE = 0; bus.ForwardBE = 0; bus.ALUResultM = 0; bus.ResultW = 0;
    last_pc = 0;

    repeat (2) @(posedge clk);
    #1 started = 1'b1;
    check("rst ValidE", bus.ValidE, 0);
    check("rst ALUControlE", bus.ALUControlE, 0);
    check("rst operands", {bus.SrcAE, bus.SrcBE, bus.WriteDataE}, 0);
    @(negedge clk); #1 reset = 1'b0;

    // R-type SUB
    issue(7'b0110011, 3'b000, 1'b1, 32'd10, 32'd3, 32'h0, 2'b00, 1'b0, 5'b11000, 0, 0);
    check("SUB ALUControlE", bus.ALUControlE, 4'b1000);
    check("SUB SrcAE", bus.SrcAE, 32'd10);
    check("SUB SrcBE", bus.SrcBE, 32'd3);
    check("SUB ValidE", bus.ValidE, 1);
    // SRAI, then ADDI with instr[30] set
    issue(7'b0010011, 3'b101, 1'b1, 32'h8000_0000, 32'h0, 32'h405, 2'b00, 1'b1, 5'b11000, 0, 0);
    check("SRAI ALUControlE", bus.ALUControlE, 4'b1101);
    check("SRAI SrcBE", bus.SrcBE, 32'h405);
    issue(7'b0010011, 3'b000, 1'b1, 32'h7, 32'h0, 32'hFFFF_FC00, 2'b00, 1'b1, 5'b11000, 0, 0);
    check("ADDI ALUControlE", bus.ALUControlE, 4'b0000);
    check("ADDI IllegalE", bus.IllegalE, 0);
    // R-type with instr[30] on AND is illegal
    issue(7'b0110011, 3'b111, 1'b1, 32'h1, 32'h2, 32'h0, 2'b00, 1'b0, 5'b11000, 0, 0);
    check("R illegal IllegalE", bus.IllegalE, 1);
    check("R illegal ALUControlE", bus.ALUControlE, 4'b0000);
    // BLTU, and reserved branch funct3
    issue(7'b1100011, 3'b110, 1'b0, 32'h5, 32'h6, 32'h10, 2'b00, 1'b0, 5'b10010, 0, 0);
    check("BLTU ALUControlE", bus.ALUControlE, 4'b0011);
    check("BLTU BranchE", bus.BranchE, 1);
    issue(7'b1100011, 3'b010, 1'b0, 32'h5, 32'h6, 32'h10, 2'b00, 1'b0, 5'b10010, 0, 0);
    check("B010 IllegalE", bus.IllegalE, 1);
    // LUI selects zero for A and the immediate for B
    issue(7'b0110111, 3'b000, 1'b0, 32'd77, 32'd88, 32'hABCDE000, 2'b10, 1'b1, 5'b11000, 0, 0);
    check("LUI SrcAE", bus.SrcAE, 32'h0);
    check("LUI SrcBE", bus.SrcBE, 32'hABCDE000);
    issue(7'b0010111, 3'b000, 1'b0, 32'd1, 32'd2, 32'h0000_3000, 2'b01, 1'b1, 5'b11000, 0, 0);
    check("AUIPC SrcAE", bus.SrcAE, last_pc);
    // Unknown opcode: ADD, illegal, control passes through
    issue(7'b1111111, 3'b011, 1'b1, 32'h3, 32'h4, 32'h0, 2'b00, 1'b0, 5'b11111, 0, 0);
    check("unk IllegalE", bus.IllegalE, 1);
    check("unk ALUControlE", bus.ALUControlE, 4'b0000);
    check("unk RegWriteE", bus.RegWriteE, 1);
    // ValidD=0 loads a bubble
    issue(7'b0110011, 3'b100, 1'b0, 32'h3, 32'h4, 32'h0, 2'b00, 1'b0, 5'b01100, 0, 0);
    check("novalid ValidE", bus.ValidE, 0);
    check("novalid RegWriteE", bus.RegWriteE, 0);
    // Sweep R-type and I-ALU encodings through the model
    for (int i = 0; i < 16; i++) begin
      issue(7'b0110011, i[2:0], i[3], 32'(i * 3), 32'(i + 100), 32'h0, 2'b00, 1'b0, 5'b11000, 0, 0);
      issue(7'b0010011, i[2:0], i[3], 32'(i * 7), 32'h0, 32'(i), 2'b00, 1'b1, 5'b11000, 0, 0);
    end

    // Forwarding is combinational: change sources while E holds
    issue(7'b0110011, 3'b000, 1'b0, 32'd5, 32'd7, 32'h0, 2'b00, 1'b0, 5'b11000, 0, 0);
    bus.StallE = 1'b1;
    bus.ALUResultM = 32'h1234;  bus.ResultW = 32'h99;  bus.ForwardAE = 2'b10;
    #1;
`ifdef FORWARDING_EN
    check("fwd A10", bus.SrcAE, 32'h1234);
`else
    check("fwd A10", bus.SrcAE, 32'd5);
`endif
    bus.ForwardAE = 2'b01;  bus.ForwardBE = 2'b10;
    #1;
`ifdef FORWARDING_EN
    check("fwd A01", bus.SrcAE, 32'h99);
    check("fwd B10", bus.WriteDataE, 32'h1234);
`else
    check("fwd A01", bus.SrcAE, 32'd5);
    check("fwd B10", bus.WriteDataE, 32'd7);
`endif
    bus.ForwardAE = 2'b11;  bus.ForwardBE = 2'b01;
    @(posedge clk); #1;
    bus.ForwardAE = 2'b00;  bus.ForwardBE = 2'b00;

    // Stall holds for two cycles, then stall+flush inserts a bubble
    issue(7'b0110011, 3'b110, 1'b0, 32'h11, 32'h22, 32'h0, 2'b00, 1'b0, 5'b11000, 0, 0);
    issue(7'b1101111, 3'b000, 1'b0, 32'h33, 32'h44, 32'h8, 2'b01, 1'b1, 5'b10101, 1, 0);
    issue(7'b0100011, 3'b010, 1'b0, 32'h55, 32'h66, 32'h4, 2'b00, 1'b1, 5'b10100, 1, 0);
    check("stall RegWriteE", bus.RegWriteE, 1);
    check("stall JumpE", bus.JumpE, 0);
    check("stall ALUControlE", bus.ALUControlE, 4'b0110);
    check("stall PCE", bus.PCE, last_pc);
    issue(7'b0110011, 3'b000, 1'b1, 32'h77, 32'h88, 32'h0, 2'b00, 1'b0, 5'b11000, 1, 1);
    check("flush ValidE", bus.ValidE, 0);
    check("flush RegWriteE", bus.RegWriteE, 0);
    check("flush ALUControlE", bus.ALUControlE, 4'b0000);

    // Async reset between clock edges
    issue(7'b0100011, 3'b010, 1'b0, 32'h100, 32'h200, 32'h4, 2'b00, 1'b1, 5'b11100, 0, 0);
    check("pre-rst MemWriteE", bus.MemWriteE, 1);
    @(negedge clk); #1 reset = 1'b1;
    #1;
    check("async ValidE", bus.ValidE, 0);
    check("async RegWriteE", bus.RegWriteE, 0);
    check("async MemWriteE", bus.MemWriteE, 0);
    @(negedge clk); #1 reset = 1'b0;
    issue(7'b0110011, 3'b101, 1'b1, 32'hF000_0000, 32'h4, 32'h0, 2'b00, 1'b0, 5'b11000, 0, 0);
    check("post-rst ALUControlE", bus.ALUControlE, 4'b1101);
    @(negedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
